// File: rtl/pps_phase_meas_n.sv
// pps_phase_meas_n: N-channel PPS phase meter.
// Every channel's rising edge is timestamped against one free-running counter.
// Each channel's signed offset from the reference channel is then reported
// through a valid/ready handshake.
// Optional feature macro: PPS_PHASE_PERIOD_EN adds o_ref_period, which is the
// reference-to-reference interval between consecutive armed windows.
`timescale 1ns/1ps

module pps_phase_meas_n #(
    parameter int          NCH         = 4,
    parameter int          CNT_W       = 29,
    parameter int          REF_CH      = 0,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned WIN_CYC     = 40000000
) (
    input  logic                 i_clk,
    input  logic                 i_res_n,
    input  logic [NCH-1:0]       i_pps,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [NCH*CNT_W-1:0] o_ph,
    output logic [NCH-1:0]       o_seen,
    output logic                 o_overrun
`ifdef PPS_PHASE_PERIOD_EN
    ,
    output logic [CNT_W-1:0]     o_ref_period
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2
    } state_t;

    localparam logic [31:0]    WIN_LAST = 32'(WIN_CYC - 32'd1);
    localparam logic [NCH-1:0] REF_MASK = NCH'(1) << REF_CH;

    // Offset of one timestamp from another, wrapping modulo 2^CNT_W.
    function automatic logic signed [CNT_W-1:0] phase_diff(
        input logic [CNT_W-1:0] ts_ch,
        input logic [CNT_W-1:0] ts_base
    );
        return signed'(ts_ch - ts_base);
    endfunction

    logic [CNT_W-1:0] cnt;
    logic [NCH-1:0]   pps_sync [SYNC_STAGES];
    logic [NCH-1:0]   pps_hist_p0;
    logic [NCH-1:0]   trig_p1;
    logic [CNT_W-1:0] cap      [NCH];
    logic [CNT_W-1:0] cap_nx   [NCH];
    logic [NCH-1:0]   seen;
    logic [NCH-1:0]   seen_nx;
    logic [31:0]      win;
    state_t           state;
    state_t           state_nx;
    logic             report_go;
    logic             drop;

    // Free-running timestamp counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Stage p0/p1: synchroniser chain, history flop and registered rising-edge detect.
    // The latency is identical on every channel, so it cancels in the offsets.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                pps_sync[k] <= '0;
            end
            pps_hist_p0 <= '0;
            trig_p1     <= '0;
        end else begin
            pps_sync[0] <= i_pps;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                pps_sync[k] <= pps_sync[k-1];
            end
            pps_hist_p0 <= pps_sync[SYNC_STAGES-1];
            trig_p1     <= pps_sync[SYNC_STAGES-1] & ~pps_hist_p0;
        end
    end

    // Same-cycle view of capture state: a trig this cycle already counts as seen/captured.
    always_comb begin
        seen_nx = seen | trig_p1;
        for (int i = 0; i < NCH; i++) begin
            cap_nx[i] = trig_p1[i] ? cnt : cap[i];
        end
    end

    // Stage p2: timestamp capture. It runs in every state, and a later edge overwrites the earlier one.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            for (int i = 0; i < NCH; i++) begin
                cap[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cap[i] <= cap_nx[i];
            end
        end
    end

    // Seen flags accumulate until a report. An edge landing in the report cycle carries over.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            seen <= '0;
        end else if (report_go) begin
            seen <= trig_p1;
        end else begin
            seen <= seen_nx;
        end
    end

    // Collection window counter; it runs only while collecting.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            win <= '0;
        end else if (state == COLLECT) begin
            win <= win + 32'd1;
        end else begin
            win <= '0;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic. Reference edges that cannot arm a window are dropped and flagged.
    always_comb begin
        state_nx  = state;
        report_go = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (trig_p1[REF_CH]) begin
                    state_nx = COLLECT;
                end
            end
            COLLECT: begin
                drop = trig_p1[REF_CH];
                if ((win == WIN_LAST) || (&seen_nx)) begin
                    state_nx  = REPORT;
                    report_go = 1'b1;
                end
            end
            REPORT: begin
                drop = trig_p1[REF_CH];
                if (i_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign o_valid = (state == REPORT);

    // Result registers, loaded once per window and held stable through the handshake.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            o_ph   <= '0;
            o_seen <= '0;
        end else if (report_go) begin
            for (int i = 0; i < NCH; i++) begin
                if ((i == REF_CH) || !seen_nx[i]) begin
                    o_ph[i*CNT_W +: CNT_W] <= '0;
                end else begin
                    o_ph[i*CNT_W +: CNT_W] <= phase_diff(cap_nx[i], cap_nx[REF_CH]);
                end
            end
            o_seen <= seen_nx | REF_MASK;
        end
    end

    // One-cycle overrun flag for each dropped reference edge.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= drop;
        end
    end

`ifdef PPS_PHASE_PERIOD_EN
    logic             arm;
    logic [CNT_W-1:0] prev_ref;
    logic             prev_ok;
    logic             armed_once;

    assign arm = (state == IDLE) && trig_p1[REF_CH];

    // At arming, cap of the reference still holds the previous reference edge; keep it as the period base.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            prev_ref   <= '0;
            prev_ok    <= 1'b0;
            armed_once <= 1'b0;
        end else if (arm) begin
            prev_ref   <= cap[REF_CH];
            prev_ok    <= armed_once;
            armed_once <= 1'b1;
        end
    end

    // Reference period, reported alongside the offsets; zero until two windows have been armed.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            o_ref_period <= '0;
        end else if (report_go) begin
            o_ref_period <= prev_ok ? phase_diff(cap_nx[REF_CH], prev_ref) : '0;
        end
    end
`endif

endmodule
